// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the player-input path: the PS/2 prefix decoder state
// encoding, the special set-2 scan codes, and the WASD make codes that the
// direction-code combiner also uses.
// -----------------------------------------------------------------------------
package input_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

    // Bytes the keyboard sends after a self-test or an error; any of them
    // means the held-key picture can no longer be trusted.
    function automatic logic is_table_clear_code(input logic [7:0] code);
        return (code == SC_BAT) || (code == SC_ERR0) || (code == SC_ERR1);
    endfunction

endpackage : input_pkg

// File: rtl/prefix_timeout_counter.sv
// -----------------------------------------------------------------------------
// prefix_timeout_counter
// Saturating idle counter that flags an abandoned prefix sequence.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   clear_i   restart counting (a byte arrived)
//   en_i      count this clock (a prefix is pending)
//   expire_o  high in the cycle the count has reached LIMIT-1 while enabled
// -----------------------------------------------------------------------------
module prefix_timeout_counter #(
    parameter logic [15:0] LIMIT = 16'd50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        expire_s;

    assign expire_s = en_i && (cnt_q == (LIMIT - 16'd1));
    assign expire_o = expire_s;

    // Next count: held at zero when idle, restarted on a byte or on expiry,
    // otherwise incremented without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_s || !en_i) begin
            cnt_d = 16'd0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : prefix_timeout_counter

// File: rtl/key_press_tracker.sv
// -----------------------------------------------------------------------------
// key_press_tracker
// Turns the PS/2 set-2 byte stream into a two-entry held-key table in press
// order. Make/break/extended prefixes are decoded, typematic repeats are
// ignored, and extended keys are not tracked.
// Ports:
//   Clk         system clock
//   Reset_n     asynchronous active-low reset
//   scan_valid  one-cycle strobe qualifying scan_code
//   scan_code   received byte
//   keyCount    number of held keys (0..2)
//   keyCode1    oldest held make code, 00 when empty
//   keyCode2    second held make code, 00 when empty
//   table_full  keyCount == 2
//   dropped     one-cycle pulse when a new make is refused (table full)
// -----------------------------------------------------------------------------
module key_press_tracker
    import input_pkg::*;
#(
    parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000,
    parameter int          MAX_KEYS       = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [2:0] keyCount,
    output logic [7:0] keyCode1,
    output logic [7:0] keyCode2,
    output logic       table_full,
    output logic       dropped
);

    localparam logic [2:0] FULL_CNT = 3'(MAX_KEYS);

    kbd_state_t state_q, state_d, state_eff_s;
    logic [2:0] count_q, count_d;
    logic [7:0] code1_q, code1_d;
    logic [7:0] code2_q, code2_d;
    logic       full_q, full_d;
    logic       drop_q, drop_d;
    logic       make_s, brk_s, clr_s;
    logic       expire_s;

    prefix_timeout_counter #(
        .LIMIT(PREFIX_TIMEOUT)
    ) u_timeout (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .clear_i (scan_valid),
        .en_i    (state_q != IDLE),
        .expire_o(expire_s)
    );

    // Prefix decoder: classifies the incoming byte as make, break or clear.
    // An expiring prefix is abandoned first, so a byte landing on that same
    // cycle is interpreted from IDLE.
    always_comb begin
        state_eff_s = expire_s ? IDLE : state_q;
        state_d     = state_eff_s;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        clr_s       = 1'b0;
        if (scan_valid) begin
            case (state_eff_s)
                IDLE: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = BRK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = EXT;
                    end else if (is_table_clear_code(scan_code)) begin
                        clr_s = 1'b1;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                BRK: begin
                    brk_s   = 1'b1;
                    state_d = IDLE;
                end
                EXT: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_eff_s;
        end
    end

    // Held-key table update. A code is only matched against occupied slots,
    // and a break of the oldest key shifts the younger one down so press
    // order is kept.
    always_comb begin
        count_d = count_q;
        code1_d = code1_q;
        code2_d = code2_q;
        drop_d  = 1'b0;
        if (clr_s) begin
            count_d = 3'd0;
            code1_d = 8'h00;
            code2_d = 8'h00;
        end else if (make_s) begin
            if (((count_q != 3'd0) && (scan_code == code1_q)) ||
                ((count_q == 3'd2) && (scan_code == code2_q))) begin
                count_d = count_q;
            end else if (count_q == 3'd0) begin
                code1_d = scan_code;
                count_d = 3'd1;
            end else if (count_q == 3'd1) begin
                code2_d = scan_code;
                count_d = 3'd2;
            end else begin
                drop_d = 1'b1;
            end
        end else if (brk_s) begin
            if ((count_q != 3'd0) && (scan_code == code1_q)) begin
                code1_d = code2_q;
                code2_d = 8'h00;
                count_d = count_q - 3'd1;
            end else if ((count_q == 3'd2) && (scan_code == code2_q)) begin
                code2_d = 8'h00;
                count_d = count_q - 3'd1;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
        full_d = (count_d == FULL_CNT);
    end

    // State and table registers; every output comes straight from here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            code1_q <= 8'h00;
            code2_q <= 8'h00;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            code1_q <= code1_d;
            code2_q <= code2_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    assign keyCount   = count_q;
    assign keyCode1   = code1_q;
    assign keyCode2   = code2_q;
    assign table_full = full_q;
    assign dropped    = drop_q;

endmodule : key_press_tracker

// File: tb/tb_key_press_tracker.sv
// -----------------------------------------------------------------------------
// tb_key_press_tracker
// Self-checking bench: directed vector table, hand-written timeout and reset
// sequences, then random byte streams compared against a queue-based model.
// -----------------------------------------------------------------------------
module tb_key_press_tracker;

    localparam logic [15:0] TO   = 16'd40;
    localparam int          TO_I = 40;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic [2:0] keyCount;
    logic [7:0] keyCode1;
    logic [7:0] keyCode2;
    logic       table_full;
    logic       dropped;

    key_press_tracker #(.PREFIX_TIMEOUT(TO), .MAX_KEYS(2)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .keyCount  (keyCount),
        .keyCode1  (keyCode1),
        .keyCode2  (keyCode2),
        .table_full(table_full),
        .dropped   (dropped)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: held keys in press order, pending prefix kind
    // (0 none, 1 break, 2 extended, 3 extended break), edge of last byte.
    logic [7:0] m_keys[$];
    int         m_pend = 0;
    int         m_edge = 0;
    int         m_last = 0;
    bit         m_drop = 1'b0;

    typedef struct {
        bit          v;
        logic [7:0]  c;
        logic [20:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [20:0] pack_exp(int n, logic [7:0] a, logic [7:0] b, bit d);
        logic full;
        full = (n == 2);
        return {3'(n), a, b, full, d};
    endfunction

    function automatic vec_t mk(bit v, logic [7:0] c, int n, logic [7:0] a, logic [7:0] b, bit d);
        vec_t r;
        r.v   = v;
        r.c   = c;
        r.exp = pack_exp(n, a, b, d);
        return r;
    endfunction

    function automatic logic [20:0] model_exp();
        logic [7:0] a;
        logic [7:0] b;
        int         n;
        a = 8'h00;
        b = 8'h00;
        n = m_keys.size();
        if (n > 0) a = m_keys[0];
        if (n > 1) b = m_keys[1];
        return pack_exp(n, a, b, m_drop);
    endfunction

    task automatic check(input string name, input logic [20:0] exp);
        logic [20:0] act;
        act = {keyCount, keyCode1, keyCode2, table_full, dropped};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got cnt=%0d k1=%h k2=%h full=%b drop=%b, want cnt=%0d k1=%h k2=%h full=%b drop=%b",
                     name, $time, act[20:18], act[17:10], act[9:2], act[1], act[0],
                     exp[20:18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_byte(input logic [7:0] c);
        int idx;
        if ((m_pend != 0) && ((m_edge - m_last) >= TO_I)) m_pend = 0;
        m_last = m_edge;
        case (m_pend)
            0: begin
                if (c == 8'hF0) m_pend = 1;
                else if (c == 8'hE0) m_pend = 2;
                else if (c == 8'hAA || c == 8'h00 || c == 8'hFF) m_keys.delete();
                else begin
                    idx = -1;
                    foreach (m_keys[i]) if (m_keys[i] == c) idx = i;
                    if (idx < 0) begin
                        if (m_keys.size() < 2) m_keys.push_back(c);
                        else m_drop = 1'b1;
                    end
                end
            end
            1: begin
                idx = -1;
                foreach (m_keys[i]) if (m_keys[i] == c) idx = i;
                if (idx >= 0) m_keys.delete(idx);
                m_pend = 0;
            end
            2: m_pend = (c == 8'hF0) ? 3 : 0;
            default: m_pend = 0;
        endcase
    endtask

    // One clock: present inputs, advance the model, sample 1 time unit after
    // the edge and compare with the model.
    task automatic cycle(input bit v, input logic [7:0] c);
        scan_valid = v;
        scan_code  = c;
        m_edge++;
        m_drop = 1'b0;
        if (v) model_byte(c);
        @(posedge Clk);
        #1;
        check("model", model_exp());
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic model_clear();
        m_keys.delete();
        m_pend = 0;
        m_drop = 1'b0;
    endtask

    initial begin
        Reset_n    = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        #12;
        check("reset_state", pack_exp(0, 8'h00, 8'h00, 1'b0));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Directed vectors, applied back to back from a cleared table.
        vt.push_back(mk(1, 8'h1D, 1, 8'h1D, 8'h00, 0));
        vt.push_back(mk(1, 8'h23, 2, 8'h1D, 8'h23, 0));
        vt.push_back(mk(1, 8'hF0, 2, 8'h1D, 8'h23, 0));
        vt.push_back(mk(1, 8'h1D, 1, 8'h23, 8'h00, 0));
        vt.push_back(mk(1, 8'hF0, 1, 8'h23, 8'h00, 0));
        vt.push_back(mk(1, 8'h23, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'hF0, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'h1D, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'h1C, 1, 8'h1C, 8'h00, 0));
        vt.push_back(mk(1, 8'h1C, 1, 8'h1C, 8'h00, 0));
        vt.push_back(mk(1, 8'h1C, 1, 8'h1C, 8'h00, 0));
        vt.push_back(mk(0, 8'h00, 1, 8'h1C, 8'h00, 0));
        vt.push_back(mk(1, 8'hF0, 1, 8'h1C, 8'h00, 0));
        vt.push_back(mk(1, 8'h1C, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'h1D, 1, 8'h1D, 8'h00, 0));
        vt.push_back(mk(1, 8'h1C, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'h1B, 2, 8'h1D, 8'h1C, 1));
        vt.push_back(mk(0, 8'h00, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'hF0, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'h1B, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'hE0, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'h75, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'hE0, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'hF0, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'h75, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'h1B, 2, 8'h1D, 8'h1C, 1));
        vt.push_back(mk(1, 8'hF0, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'h1C, 1, 8'h1D, 8'h00, 0));
        vt.push_back(mk(1, 8'h1C, 2, 8'h1D, 8'h1C, 0));
        vt.push_back(mk(1, 8'hAA, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'hE0, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'h1D, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'h1D, 1, 8'h1D, 8'h00, 0));
        vt.push_back(mk(1, 8'hFF, 0, 8'h00, 8'h00, 0));
        vt.push_back(mk(1, 8'h1B, 1, 8'h1B, 8'h00, 0));
        vt.push_back(mk(1, 8'h00, 0, 8'h00, 8'h00, 0));
        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].v, vt[i].c);
            check($sformatf("vec%0d", i), vt[i].exp);
        end

        // Prefix timeout boundary: one cycle short of expiry still a break.
        cycle(1, 8'h1B);
        cycle(1, 8'hF0);
        repeat (TO_I - 2) cycle(0, 8'h00);
        cycle(1, 8'h1B);
        check("brk_before_timeout", pack_exp(0, 8'h00, 8'h00, 0));
        // Byte on the expiry cycle is taken from IDLE, so it is a make.
        cycle(1, 8'hF0);
        repeat (TO_I - 1) cycle(0, 8'h00);
        cycle(1, 8'h1B);
        check("make_on_timeout", pack_exp(1, 8'h1B, 8'h00, 0));
        cycle(1, 8'hAA);
        cycle(1, 8'hF0);
        repeat (TO_I) cycle(0, 8'h00);
        cycle(1, 8'h1B);
        check("make_after_timeout", pack_exp(1, 8'h1B, 8'h00, 0));
        cycle(1, 8'hE0);
        repeat (TO_I) cycle(0, 8'h00);
        cycle(1, 8'h1D);
        check("ext_timeout", pack_exp(2, 8'h1B, 8'h1D, 0));

        // Reset in the middle of a break sequence.
        cycle(1, 8'hF0);
        #2;
        Reset_n = 1'b0;
        model_clear();
        #1;
        check("async_reset", pack_exp(0, 8'h00, 8'h00, 0));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cycle(0, 8'h00);
        cycle(0, 8'h00);
        cycle(1, 8'h1D);
        check("after_reset_make", pack_exp(1, 8'h1D, 8'h00, 0));

        // Random streams against the model.
        begin
            logic [7:0] pool [12];
            pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hF0,
                     8'hE0, 8'hAA, 8'h00, 8'hFF, 8'h75, 8'h12};
            for (int i = 0; i < 2500; i++) begin
                int gap;
                if ($urandom_range(0, 499) == 0) begin
                    #2;
                    Reset_n = 1'b0;
                    model_clear();
                    #1;
                    check("rand_reset", pack_exp(0, 8'h00, 8'h00, 0));
                    @(posedge Clk);
                    #1;
                    Reset_n = 1'b1;
                end
                if ($urandom_range(0, 19) == 0) gap = $urandom_range(TO_I - 3, TO_I + 3);
                else gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
                repeat (gap) cycle(0, 8'h00);
                if (($urandom_range(0, 6) == 0) || (i % 50 == 0)) cycle(1, 8'hAA);
                cycle(1, pool[$urandom_range(0, 11)]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_press_tracker
